// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART TX scheduler: FSM states, grant codes, counter width.
package uart_tx_sched_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_HI = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_LO = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP     = 3'd4;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the source not granted last wins.
module rr_arb2
  import uart_tx_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  logic ptr_q;

  // Grant decode: a lone requester always wins, a tie goes to the favoured source
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (en) begin
      if (req_a && (!req_b || (ptr_q == GRANT_A))) begin
        gnt_a_c = 1'b1;
      end else if (req_b) begin
        gnt_b_c = 1'b1;
      end
    end
  end

  // Pointer favours the source that was not granted on the last acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= GRANT_A;
    end else if (gnt_a_c) begin
      ptr_q <= GRANT_B;
    end else if (gnt_b_c) begin
      ptr_q <= GRANT_A;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a byte source (A) and a word source (B).
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned DATA = 8,
  parameter int unsigned GAP  = 0,
  parameter int unsigned WDOG = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  input  logic [DATA-1:0]   a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [2*DATA-1:0] b_data,
  output logic              b_ready,
  input  logic              tx_busy,
  output logic              tx_data_valid,
  output logic [DATA-1:0]   tx_p_data,
  output logic              sched_busy,
  output logic              wdog_err
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              grant_q, grant_d;
  logic              byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*DATA-1:0] payload_q, payload_d;
  logic              dv_q, dv_d;
  logic [DATA-1:0]   pdata_q, pdata_d;
  logic [DATA-1:0]   cur_byte;
  logic              in_idle;
  logic              gnt_a, gnt_b;

  assign in_idle  = (state_q == ST_IDLE);
  assign cur_byte = byte_idx_q ? payload_q[2*DATA-1:DATA] : payload_q[DATA-1:0];

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .en      (in_idle),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .gnt_a_c (gnt_a),
    .gnt_b_c (gnt_b)
  );

  assign a_ready       = gnt_a;
  assign b_ready       = gnt_b;
  assign sched_busy    = !in_idle;
  assign tx_data_valid = dv_q;
  assign tx_p_data     = pdata_q;

  // Next-state and next-output logic; cnt_q is the watchdog count in WAIT_HI
  // and the remaining idle cycles in GAP
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    dv_d       = 1'b0;
    pdata_d    = pdata_q;
    wdog_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_a) begin
          payload_d  = {{DATA{1'b0}}, a_data};
          grant_d    = GRANT_A;
          byte_idx_d = 1'b0;
          dv_d       = 1'b1;
          pdata_d    = a_data;
          state_d    = ST_LOAD;
        end else if (gnt_b) begin
          payload_d  = b_data;
          grant_d    = GRANT_B;
          byte_idx_d = 1'b0;
          dv_d       = 1'b1;
          pdata_d    = b_data[DATA-1:0];
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CNT_W'(WDOG - 1)) begin
          wdog_err = 1'b1;
          dv_d     = 1'b1;
          pdata_d  = cur_byte;
          state_d  = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if ((grant_q == GRANT_B) && !byte_idx_q) begin
            byte_idx_d = 1'b1;
            dv_d       = 1'b1;
            pdata_d    = payload_q[2*DATA-1:DATA];
            state_d    = ST_LOAD;
          end else if (GAP != 0) begin
            cnt_d   = CNT_W'(GAP - 1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, payload, counters and registered transmitter drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_A;
      byte_idx_q <= 1'b0;
      cnt_q      <= '0;
      payload_q  <= '0;
      dv_q       <= 1'b0;
      pdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      dv_q       <= dv_d;
      pdata_q    <= pdata_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (GAP=0 and GAP=3) against a request-level model.
module tb_uart_tx_sched;

  localparam int WD    = 4;
  localparam int TXLEN = 3;
  localparam int F_DV = 0, F_PD = 1, F_SB = 2, F_WD = 3, F_AR = 4, F_BR = 5;

  typedef struct {
    int          at;
    int          inst;
    int          fld;
    logic [15:0] val;
  } pin_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic        b_valid = 1'b0;
  logic [15:0] b_data = 16'h0000;

  logic        a_ready [2];
  logic        b_ready [2];
  logic        dv      [2];
  logic [7:0]  pdata   [2];
  logic        sbusy   [2];
  logic        wdog    [2];
  logic        tx_busy [2] = '{1'b0, 1'b0};
  int          tx_cnt  [2] = '{0, 0};
  bit          mute = 1'b0;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   done = 1'b0;
  bit   flushed = 1'b0;
  int   t0;
  pin_t pins [$];
  string fname [6] = '{"tx_data_valid", "tx_p_data", "sched_busy", "wdog_err", "a_ready", "b_ready"};

  // Request-level model: bytes still owed, pulse due, rise seen, waits, gap left
  int         m_n    [2];
  logic [7:0] m_b0   [2];
  logic [7:0] m_b1   [2];
  logic [7:0] m_last [2];
  bit         m_pulse[2];
  bit         m_rose [2];
  bit         m_fava [2];
  int         m_wait [2];
  int         m_gap  [2];
  bit         e_idle, e_ar, e_br, e_wd;

  uart_tx_sched #(.DATA(8), .GAP(0), .WDOG(WD)) u_dut0 (
    .CLK(clk), .RST(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready[0]),
    .tx_busy(tx_busy[0]), .tx_data_valid(dv[0]), .tx_p_data(pdata[0]),
    .sched_busy(sbusy[0]), .wdog_err(wdog[0])
  );

  uart_tx_sched #(.DATA(8), .GAP(3), .WDOG(WD)) u_dut1 (
    .CLK(clk), .RST(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready[1]),
    .tx_busy(tx_busy[1]), .tx_data_valid(dv[1]), .tx_p_data(pdata[1]),
    .sched_busy(sbusy[1]), .wdog_err(wdog[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter stand-in: busy the cycle after Data_Valid, for TXLEN cycles; not reset
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_busy[i]) begin
        if (tx_cnt[i] == 0) tx_busy[i] <= 1'b0;
        else tx_cnt[i] <= tx_cnt[i] - 1;
      end else if (dv[i] && !mute) begin
        tx_busy[i] <= 1'b1;
        tx_cnt[i]  <= TXLEN - 1;
      end
    end
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] act_of(input int i, input int f);
    case (f)
      F_DV:    return 16'(dv[i]);
      F_PD:    return 16'(pdata[i]);
      F_SB:    return 16'(sbusy[i]);
      F_WD:    return 16'(wdog[i]);
      F_AR:    return 16'(a_ready[i]);
      default: return 16'(b_ready[i]);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Compare every cycle against the model and the pinned literals, then advance the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e_idle = (m_n[i] == 0) && (m_gap[i] == 0);
        e_ar   = e_idle && a_valid && (!b_valid || m_fava[i]);
        e_br   = e_idle && b_valid && !e_ar;
        e_wd   = (m_n[i] > 0) && !m_pulse[i] && !m_rose[i] && !tx_busy[i] && (m_wait[i] == WD - 1);
        chk("tx_data_valid", i, 16'(dv[i]),      16'(m_pulse[i]));
        chk("tx_p_data",     i, 16'(pdata[i]),   16'(m_last[i]));
        chk("sched_busy",    i, 16'(sbusy[i]),   16'(!e_idle));
        chk("wdog_err",      i, 16'(wdog[i]),    16'(e_wd));
        chk("a_ready",       i, 16'(a_ready[i]), 16'(e_ar));
        chk("b_ready",       i, 16'(b_ready[i]), 16'(e_br));
      end
      for (int k = pins.size() - 1; k >= 0; k--) begin
        if (pins[k].at == cyc) begin
          chk({"pin_", fname[pins[k].fld]}, pins[k].inst, act_of(pins[k].inst, pins[k].fld), pins[k].val);
          pins.delete(k);
        end
      end
    end
    if (done && !flushed) begin
      foreach (pins[k]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pin_unreached inst%0d at %0d: got none want %0h", pins[k].inst, pins[k].at, pins[k].val);
      end
      flushed = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_n[i] = 0; m_gap[i] = 0; m_pulse[i] = 1'b0; m_rose[i] = 1'b0;
        m_wait[i] = 0; m_fava[i] = 1'b1; m_last[i] = 8'h00;
      end else if ((m_n[i] == 0) && (m_gap[i] == 0)) begin
        if (a_valid && (!b_valid || m_fava[i])) begin
          m_n[i] = 1; m_b0[i] = a_data; m_fava[i] = 1'b0;
          m_pulse[i] = 1'b1; m_last[i] = a_data;
        end else if (b_valid) begin
          m_n[i] = 2; m_b0[i] = b_data[7:0]; m_b1[i] = b_data[15:8]; m_fava[i] = 1'b1;
          m_pulse[i] = 1'b1; m_last[i] = b_data[7:0];
        end
      end else if (m_gap[i] > 0) begin
        m_gap[i]--;
      end else if (m_pulse[i]) begin
        m_pulse[i] = 1'b0; m_rose[i] = 1'b0; m_wait[i] = 0;
      end else if (!m_rose[i]) begin
        if (tx_busy[i]) m_rose[i] = 1'b1;
        else if (m_wait[i] == WD - 1) m_pulse[i] = 1'b1;
        else m_wait[i]++;
      end else if (!tx_busy[i]) begin
        m_n[i]--;
        m_b0[i] = m_b1[i];
        if (m_n[i] > 0) begin
          m_pulse[i] = 1'b1; m_last[i] = m_b0[i]; m_rose[i] = 1'b0;
        end else begin
          m_gap[i] = gap_of(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pin(input int at, input int inst, input int fld, input logic [15:0] val);
    pin_t p;
    p.at = at; p.inst = inst; p.fld = fld; p.val = val;
    pins.push_back(p);
  endtask

  task automatic pin2(input int at, input int fld, input logic [15:0] val);
    add_pin(at, 0, fld, val);
    add_pin(at, 1, fld, val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end want end");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0; chk_en = 1'b1; t0 = cyc;
    pin2(t0, F_DV, 0); pin2(t0, F_PD, 0); pin2(t0, F_SB, 0); pin2(t0, F_WD, 0);
    repeat (4) step();

    // A only
    step(); t0 = cyc; a_valid = 1'b1; a_data = 8'hA5;
    pin2(t0, F_AR, 1); pin2(t0 + 1, F_DV, 1); pin2(t0 + 1, F_PD, 16'hA5); pin2(t0 + 2, F_DV, 0);
    pin2(t0 + 5, F_SB, 1); add_pin(t0 + 6, 0, F_SB, 0);
    add_pin(t0 + 8, 1, F_SB, 1); add_pin(t0 + 9, 1, F_SB, 0);
    step(); a_valid = 1'b0;
    repeat (20) step();

    // B only: low byte then high byte the cycle after the first busy fall
    step(); t0 = cyc; b_valid = 1'b1; b_data = 16'h1234;
    pin2(t0, F_BR, 1); pin2(t0 + 1, F_DV, 1); pin2(t0 + 1, F_PD, 16'h34); pin2(t0 + 5, F_DV, 0);
    pin2(t0 + 6, F_DV, 1); pin2(t0 + 6, F_PD, 16'h12); pin2(t0 + 7, F_PD, 16'h12);
    step(); b_valid = 1'b0;
    repeat (20) step();

    // A held: acceptance spacing with GAP=0 versus GAP=3
    step(); t0 = cyc; a_valid = 1'b1; a_data = 8'h5A;
    add_pin(t0 + 1, 0, F_DV, 1); add_pin(t0 + 3, 0, F_AR, 0); add_pin(t0 + 5, 0, F_AR, 0);
    add_pin(t0 + 6, 0, F_AR, 1); add_pin(t0 + 7, 0, F_DV, 1); add_pin(t0 + 13, 0, F_DV, 1);
    add_pin(t0 + 5, 1, F_AR, 0); add_pin(t0 + 6, 1, F_AR, 0); add_pin(t0 + 8, 1, F_AR, 0);
    add_pin(t0 + 9, 1, F_AR, 1); add_pin(t0 + 10, 1, F_DV, 1);
    repeat (13) step(); a_valid = 1'b0;
    repeat (25) step();

    // Watchdog: transmitter ignores the first load, then responds to the reissue
    step(); t0 = cyc; mute = 1'b1; a_valid = 1'b1; a_data = 8'h3C;
    pin2(t0 + 1, F_DV, 1); pin2(t0 + 4, F_WD, 0); pin2(t0 + 5, F_WD, 1);
    pin2(t0 + 6, F_DV, 1); pin2(t0 + 6, F_PD, 16'h3C); pin2(t0 + 6, F_WD, 0); pin2(t0 + 7, F_SB, 1);
    step(); a_valid = 1'b0;
    repeat (4) step();
    step(); mute = 1'b0;
    repeat (20) step();

    // Reset during WAIT_LO of B's low byte; pointer back to A afterwards
    step(); t0 = cyc; b_valid = 1'b1; b_data = 16'h1234;
    pin2(t0 + 1, F_PD, 16'h34); pin2(t0 + 3, F_SB, 1); pin2(t0 + 4, F_SB, 0); pin2(t0 + 4, F_DV, 0);
    pin2(t0 + 4, F_PD, 0); pin2(t0 + 4, F_WD, 0); pin2(t0 + 6, F_DV, 0);
    step(); b_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    repeat (4) step();
    a_valid = 1'b1; a_data = 8'h77; b_valid = 1'b1; b_data = 16'hBEEF;
    pin2(t0 + 8, F_AR, 1); pin2(t0 + 8, F_BR, 0); pin2(t0 + 9, F_DV, 1); pin2(t0 + 9, F_PD, 16'h77);
    step(); a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) step();

    // Both held from reset: grants alternate A, B, A
    rst = 1'b1; step(); step(); rst = 1'b0;
    step(); t0 = cyc; a_valid = 1'b1; a_data = 8'hA5; b_valid = 1'b1; b_data = 16'h1234;
    pin2(t0, F_AR, 1); pin2(t0, F_BR, 0);
    add_pin(t0 + 1, 0, F_PD, 16'hA5); add_pin(t0 + 6, 0, F_BR, 1); add_pin(t0 + 7, 0, F_PD, 16'h34);
    add_pin(t0 + 12, 0, F_DV, 1); add_pin(t0 + 12, 0, F_PD, 16'h12);
    add_pin(t0 + 17, 0, F_AR, 1); add_pin(t0 + 18, 0, F_PD, 16'hA5);
    add_pin(t0 + 9, 1, F_BR, 1); add_pin(t0 + 10, 1, F_PD, 16'h34); add_pin(t0 + 15, 1, F_PD, 16'h12);
    add_pin(t0 + 24, 1, F_DV, 1); add_pin(t0 + 24, 1, F_PD, 16'hA5);
    repeat (24) step(); a_valid = 1'b0; b_valid = 1'b0;
    repeat (30) step();

    done = 1'b1;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
